// File: rtl/fetch_decode.sv
// Front-end fetch/decode stage: IP, instruction fetch, local branch resolution, 8x16 register file.
// Optional macro FETCH_DECODE_WB_BYPASS_EN forwards same-cycle write-back data into DECODE operand reads.
module fetch_decode #(
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        id_valid,
  input  logic        ex_ready,
  output logic [15:0] id_opcode,
  output logic [15:0] id_regA,
  output logic [15:0] id_regB,
  output logic [15:0] id_imm,
  output logic [2:0]  id_dst,
  output logic [15:0] id_ip,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    ISSUE  = 2'd2,
    HALT   = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] ip;
  logic [15:0] ir;
  logic [15:0] rf [8];
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] br_off;
  logic        taken;

  assign imem_addr = ip;
  assign dbg_state = state;

  assign br_off = {{7{ir[8]}}, ir[8:0]};
  assign taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

  always_comb begin
    op_a = rf[ir[11:9]];
    op_b = rf[ir[2:0]];
`ifdef FETCH_DECODE_WB_BYPASS_EN
    if (wb_en && (wb_addr == ir[11:9])) op_a = wb_data;
    if (wb_en && (wb_addr == ir[2:0]))  op_b = wb_data;
`endif
  end

  // Write port is independent of the FSM: the ALU may retire at any time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Handshakes: imem_req stays high and imem_addr stable until the cycle imem_ack=1;
  // id_valid and the id_* bundle stay stable until the cycle ex_ready=1 (transfer on id_valid & ex_ready).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      ip        <= RESET_IP;
      ir        <= '0;
      imem_req  <= 1'b0;
      id_valid  <= 1'b0;
      id_opcode <= '0;
      id_regA   <= '0;
      id_regB   <= '0;
      id_imm    <= '0;
      id_dst    <= '0;
      id_ip     <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // First cycle out of reset only raises the request; acks are ignored until then.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          case (ir[15:12])
            4'b1100: begin
              ip       <= taken ? (ip + 16'd1 + br_off) : (ip + 16'd1);
              imem_req <= 1'b1;
              state    <= FETCH;
            end
            4'b1111: begin
              halted <= 1'b1;
              state  <= HALT;
            end
            default: begin
              id_opcode <= ir;
              id_regA   <= op_a;
              id_regB   <= op_b;
              id_imm    <= {{11{ir[4]}}, ir[4:0]};
              id_dst    <= ir[11:9];
              id_ip     <= ip;
              id_valid  <= 1'b1;
              state     <= ISSUE;
            end
          endcase
        end
        ISSUE: begin
          if (ex_ready) begin
            id_valid <= 1'b0;
            ip       <= ip + 16'd1;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        HALT: begin
          halted   <= 1'b1;
          imem_req <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage of the 16-bit core: holds the instruction pointer, fetches one instruction word per transaction from instruction memory, resolves conditional branches locally from the n/z/p flags, reads two operands from an internal 8x16 register file and presents a registered decoded bundle to the ALU stage over a valid/ready handshake. The ALU result is written back into the register file through a dedicated write port.

## Interface
- `RESET_IP`, 16'h0000, IP value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  fetch request, held until `imem_ack`.
- `imem_addr`  out  16  fetch address (current IP).
- `imem_ack`  in  1  `imem_rdata` valid this cycle; sampled only while `imem_req`=1.
- `imem_rdata`  in  16  instruction word.
- `n`, `z`, `p`  in  1 each  flag register from the ALU stage.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  3  write index.
- `wb_data`  in  16  write data.
- `id_valid`  out  1  decoded bundle valid.
- `ex_ready`  in  1  ALU stage accepts bundle when `id_valid & ex_ready`.
- `id_opcode`  out  16  raw instruction word.
- `id_regA`, `id_regB`  out  16 each  operands R[ir[11:9]], R[ir[2:0]].
- `id_imm`  out  16  sign-extended ir[4:0].
- `id_dst`  out  3  destination index ir[11:9].
- `id_ip`  out  16  IP of the issued instruction.
- `halted`  out  1  core stopped on HALT.

## Operation
- States: FETCH, DECODE, ISSUE, HALT. Reset -> FETCH.
- FETCH: `imem_req`=1, `imem_addr`=IP. On `imem_ack`: IR <= `imem_rdata`, -> DECODE. Without ack: stay, request and address stable.
- DECODE, by ir[15:12]:
  - 4'b1100 BR: taken = (ir[11]&n)|(ir[10]&z)|(ir[9]&p). IP <= IP+1+sext(ir[8:0]) if taken, else IP+1. -> FETCH. Nothing issued. ir[11:9]=000 is never taken.
  - 4'b1111 HALT: -> HALT, IP unchanged.
  - All other codes (0000–1011, 1101, 1110): load `id_*` registers from IR and register file, -> ISSUE.
- ISSUE: `id_valid`=1, all `id_*` stable. On `ex_ready`: IP <= IP+1, -> FETCH. Otherwise hold.
- HALT: `halted`=1, no requests, leaves only on reset.
- Register file: 8x16, all zero on reset. Write on every `wb_en` cycle regardless of state. R0 is an ordinary register.
- IP arithmetic is 16-bit modulo: 16'hFFFF + 1 = 16'h0000. Branch offset range is −256..+255 relative to IP+1.
- Flags are sampled only in the DECODE cycle of a BR.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_IP`, `id_valid`=0, `id_opcode`/`id_regA`/`id_regB`/`id_imm`/`id_ip`=0, `id_dst`=0, `halted`=0, IP=`RESET_IP`. `imem_req` rises the first cycle after reset deasserts.
- Zero-wait memory (ack in the first FETCH cycle): ALU instruction = 3 cycles (FETCH, DECODE, ISSUE with immediate `ex_ready`). BR = 2 cycles.
- `imem_rdata` is captured only in the ack cycle. An ack while `imem_req`=0 is ignored.
- Reset in any state aborts the pending fetch or issue, drops `id_valid` and `imem_req` the next cycle, and clears the register file. Memory must not deliver a stale ack after reset.
- Flags driven by the ALU stage must settle before the cycle after the preceding bundle is accepted. The FETCH state in between guarantees this.

## Configuration
- `FETCH_DECODE_WB_BYPASS_EN` defined: an operand read in DECODE whose index equals `wb_addr` while `wb_en`=1 returns `wb_data` in that same cycle.
- Undefined: DECODE returns the pre-write register contents. The new value is visible from the next cycle. Software must insert a gap.

## Test plan
- Reset with `RESET_IP`=16'h0010: all outputs at their reset values. First `imem_addr`=16'h0010 with `imem_req`=1 one cycle after reset release.
- Write R1=16'h0005 via wb. Fetch 16'h0201 (ADD, A=R1, B=R1) with `ex_ready`=1 -> `id_regA`=`id_regB`=16'h0005, `id_dst`=1, `id_ip`=16'h0010. Next fetch at 16'h0011.
- Hold `ex_ready`=0 for 4 cycles -> `id_valid` and the bundle stay stable and IP is unchanged. Raise `ex_ready` -> one accept and IP+1.
- BR 16'hC9FE (n-bit set, offset −2) at IP 16'h0020 with n=1 -> next `imem_addr`=16'h001F. With n=0,z=1 -> 16'h0021.
- `wb_en`=1, `wb_addr`=3, `wb_data`=16'hBEEF in the DECODE cycle reading R3 -> `id_regA`=16'hBEEF with the macro defined, the old value without it.
- HALT 16'hF000 -> `halted`=1, no further `imem_req`. Assert `rst_n`=0 during ack wait -> state is FETCH at `RESET_IP`. Fetch at IP 16'hFFFF -> next IP is 16'h0000.
